// File: rtl/button_compositor.sv
// button_compositor
// Maps VGA scan coordinates onto two on-screen buttons, feeds button-local
// coordinates to the button ROM reader, and composites the returned RGB over
// the background stream. Also tracks which button is highlighted, runs the
// confirm-flash sequence and reports the chosen button to game logic.
//
// Ports:
//   vga_clk, reset         pixel clock, synchronous active-high reset
//   pixel_x, pixel_y       current scan position (T0)
//   frame_start            one-cycle pulse per frame
//   bg_data                background RGB aligned with pixel_x/pixel_y
//   sel_toggle, confirm    user input pulses
//   btn_x_pos, btn_y_pos,
//   btn_type               button-local address to ROM reader (T1)
//   btn_pixel              ROM reader RGB (T2)
//   out_data               composited RGB to DAC (T3)
//   choice_valid, choice   confirm result pulse and held button index
//
// Configuration macro: TRANSPARENT_KEY_EN -- when defined, magenta (24'hFF00FF)
// button pixels show the background instead.

module button_compositor #(
  parameter int unsigned BTN_W        = 155,
  parameter int unsigned BTN_H        = 38,
  parameter int unsigned BTN0_X       = 80,
  parameter int unsigned BTN0_Y       = 400,
  parameter int unsigned BTN1_X       = 400,
  parameter int unsigned BTN1_Y       = 400,
  parameter logic [23:0] HILITE_MASK  = 24'h303030,
  parameter int unsigned FLASH_FRAMES = 16
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        frame_start,
  input  logic [23:0] bg_data,
  input  logic        sel_toggle,
  input  logic        confirm,
  output logic [7:0]  btn_x_pos,
  output logic [5:0]  btn_y_pos,
  output logic        btn_type,
  input  logic [23:0] btn_pixel,
  output logic [23:0] out_data,
  output logic        choice_valid,
  output logic        choice
);

  // Counter is at least 2 bits so bit 1 can drive the flash blink.
  localparam int unsigned CNT_W = (FLASH_FRAMES > 4) ? $clog2(FLASH_FRAMES) : 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  // Region bounds at 11 bits so the end coordinate cannot wrap.
  localparam logic [10:0] X0_LO = 11'(BTN0_X);
  localparam logic [10:0] X0_HI = 11'(BTN0_X + BTN_W);
  localparam logic [10:0] Y0_LO = 11'(BTN0_Y);
  localparam logic [10:0] Y0_HI = 11'(BTN0_Y + BTN_H);
  localparam logic [10:0] X1_LO = 11'(BTN1_X);
  localparam logic [10:0] X1_HI = 11'(BTN1_X + BTN_W);
  localparam logic [10:0] Y1_LO = 11'(BTN1_Y);
  localparam logic [10:0] Y1_HI = 11'(BTN1_Y + BTN_H);
  localparam logic [9:0]  X0_OFS = 10'(BTN0_X);
  localparam logic [9:0]  Y0_OFS = 10'(BTN0_Y);
  localparam logic [9:0]  X1_OFS = 10'(BTN1_X);
  localparam logic [9:0]  Y1_OFS = 10'(BTN1_Y);

`ifdef TRANSPARENT_KEY_EN
  localparam logic [23:0] KEY_COLOR = 24'hFF00FF;
`endif

  typedef enum logic [1:0] {IDLE, FLASH, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             highlight, highlight_n;
  logic             hilite_on_c;

  logic             hit0_c, hit1_c, hit_c;
  logic [10:0]      px_c, py_c;
  logic             hit_d1, hit_d2;
  logic             sel_d2;
  logic [23:0]      bg_d1, bg_d2;
  logic [23:0]      out_c;

  // Hit detection on the raw scan position; button 0 wins an overlap.
  always_comb begin
    px_c   = {1'b0, pixel_x};
    py_c   = {1'b0, pixel_y};
    hit0_c = (px_c >= X0_LO) && (px_c < X0_HI) && (py_c >= Y0_LO) && (py_c < Y0_HI);
    hit1_c = (px_c >= X1_LO) && (px_c < X1_HI) && (py_c >= Y1_LO) && (py_c < Y1_HI);
    hit_c  = hit0_c || hit1_c;
  end

  // Stage 1: ROM address (held when no button is under the beam), stage 2 delay.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      btn_x_pos <= 8'd0;
      btn_y_pos <= 6'd0;
      btn_type  <= 1'b0;
      hit_d1    <= 1'b0;
      hit_d2    <= 1'b0;
      sel_d2    <= 1'b0;
      bg_d1     <= 24'd0;
      bg_d2     <= 24'd0;
    end else begin
      hit_d1 <= hit_c;
      bg_d1  <= bg_data;
      if (hit0_c) begin
        btn_x_pos <= 8'(pixel_x - X0_OFS);
        btn_y_pos <= 6'(pixel_y - Y0_OFS);
        btn_type  <= 1'b0;
      end else if (hit1_c) begin
        btn_x_pos <= 8'(pixel_x - X1_OFS);
        btn_y_pos <= 6'(pixel_y - Y1_OFS);
        btn_type  <= 1'b1;
      end
      hit_d2 <= hit_d1;
      sel_d2 <= btn_type;
      bg_d2  <= bg_d1;
    end
  end

  // Stage 3 compose: background, button pixel, or highlighted button pixel.
  always_comb begin
    out_c = bg_d2;
    if (hit_d2) begin
      out_c = btn_pixel;
      if (hilite_on_c && (sel_d2 == highlight)) begin
        out_c = btn_pixel ^ HILITE_MASK;
      end
`ifdef TRANSPARENT_KEY_EN
      if (btn_pixel == KEY_COLOR) begin
        out_c = bg_d2;
      end
`endif
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      out_data <= 24'd0;
    end else begin
      out_data <= out_c;
    end
  end

  // Selection FSM: state and registered outputs.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      highlight    <= 1'b0;
      choice_valid <= 1'b0;
      choice       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      highlight    <= highlight_n;
      choice_valid <= (state_n == DONE);
      if (state_n == DONE) begin
        choice <= highlight;
      end
    end
  end

  // Selection FSM: next state; confirm outranks sel_toggle in IDLE.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    highlight_n = highlight;
    hilite_on_c = 1'b1;
    case (state)
      IDLE: begin
        if (confirm) begin
          state_n = FLASH;
          cnt_n   = '0;
        end else if (sel_toggle) begin
          highlight_n = ~highlight;
        end
      end
      FLASH: begin
        hilite_on_c = cnt[1];
        if (frame_start) begin
          if (cnt == CNT_LAST) begin
            state_n = DONE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_compositor.sv
// Testbench for button_compositor: table-driven pixel scans checked through a
// latency-3 scoreboard, plus hand-written confirm/flash/reset sequences.

module tb_button_compositor;

  localparam logic [23:0] MASK = 24'h303030;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        frame_start;
  logic [23:0] bg_data;
  logic        sel_toggle, confirm;
  logic [7:0]  btn_x_pos;
  logic [5:0]  btn_y_pos;
  logic        btn_type;
  logic [23:0] btn_pixel;
  logic [23:0] out_data;
  logic        choice_valid, choice;

  button_compositor dut (
    .vga_clk(vga_clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .bg_data(bg_data), .sel_toggle(sel_toggle),
    .confirm(confirm), .btn_x_pos(btn_x_pos), .btn_y_pos(btn_y_pos),
    .btn_type(btn_type), .btn_pixel(btn_pixel), .out_data(out_data),
    .choice_valid(choice_valid), .choice(choice)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] bg;
    logic        hit;
    logic        typ;
    logic [7:0]  lx;
    logic [5:0]  ly;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [23:0] exp;
    int          idx;
  } sb_t;

  vec_t tbl [13];
  sb_t  sb_q [$];

  int unsigned cyc = 0;
  int          cv_count = 0;
  logic        cv_choice = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic [7:0]  m_lx = 8'd0;
  logic [5:0]  m_ly = 6'd0;
  logic        m_typ = 1'b0;

  // Image content stands in for the ROM; (77,7) is magenta in both buttons.
  function automatic logic [23:0] rom(input logic typ, input logic [5:0] ly, input logic [7:0] lx);
    if (lx == 8'd77 && ly == 6'd7) return 24'hFF00FF;
    return {typ, 1'b0, ly, lx, lx ^ 8'h5A};
  endfunction

  // ROM reader stub: one cycle from address to data.
  always @(posedge vga_clk) begin
    btn_pixel <= rom(btn_type, btn_y_pos, btn_x_pos);
    cyc <= cyc + 1;
  end

  always @(negedge vga_clk) begin
    if (choice_valid) begin
      cv_count  <= cv_count + 1;
      cv_choice <= choice;
    end
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  function automatic logic [23:0] exp_out(input vec_t v, input logic hl, input logic hon);
    logic [23:0] p;
    if (!v.hit) return v.bg;
    p = rom(v.typ, v.ly, v.lx);
`ifdef TRANSPARENT_KEY_EN
    if (p == 24'hFF00FF) return v.bg;
`endif
    if (hon && v.typ == hl) p = p ^ MASK;
    return p;
  endfunction

  task automatic sb_pop();
    sb_t e;
    while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      chk($sformatf("out_data[%0d]", e.idx), out_data, e.exp);
    end
  endtask

  // Stream table entries one per cycle, then drain the scoreboard.
  task automatic run_scan(input int first, input int last, input logic hl, input logic hon);
    sb_t e;
    for (int i = first; i <= last; i++) begin
      pixel_x = tbl[i].x;
      pixel_y = tbl[i].y;
      bg_data = tbl[i].bg;
      e.due = cyc + 3;
      e.exp = exp_out(tbl[i], hl, hon);
      e.idx = i;
      sb_q.push_back(e);
      if (tbl[i].hit) begin
        m_lx = tbl[i].lx; m_ly = tbl[i].ly; m_typ = tbl[i].typ;
      end
      step();
      chk($sformatf("btn_x_pos[%0d]", i), 24'(btn_x_pos), 24'(m_lx));
      chk($sformatf("btn_y_pos[%0d]", i), 24'(btn_y_pos), 24'(m_ly));
      chk($sformatf("btn_type[%0d]", i), 24'(btn_type), 24'(m_typ));
      sb_pop();
    end
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    bg_data = 24'd0;
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      step();
      sb_pop();
    end
    if (sb_q.size() > 0) begin
      chk("scoreboard_drain", 24'(sb_q.size()), 24'd0);
      sb_q.delete();
    end
  endtask

  task automatic pulse_frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      step();
    end
  endtask

  int cv_snap;

  initial begin
    //          x        y        bg            hit   typ   lx      ly
    tbl[0]  = '{10'd80,  10'd400, 24'h010203, 1'b1, 1'b0, 8'd0,   6'd0};
    tbl[1]  = '{10'd554, 10'd437, 24'h0A0B0C, 1'b1, 1'b1, 8'd154, 6'd37};
    tbl[2]  = '{10'd555, 10'd437, 24'hABCDEF, 1'b0, 1'b0, 8'd0,   6'd0};
    tbl[3]  = '{10'd79,  10'd400, 24'h111111, 1'b0, 1'b0, 8'd0,   6'd0};
    tbl[4]  = '{10'd234, 10'd437, 24'h222222, 1'b1, 1'b0, 8'd154, 6'd37};
    tbl[5]  = '{10'd235, 10'd400, 24'h333333, 1'b0, 1'b0, 8'd0,   6'd0};
    tbl[6]  = '{10'd400, 10'd400, 24'h444444, 1'b1, 1'b1, 8'd0,   6'd0};
    tbl[7]  = '{10'd100, 10'd438, 24'h555555, 1'b0, 1'b0, 8'd0,   6'd0};
    tbl[8]  = '{10'd100, 10'd399, 24'h666666, 1'b0, 1'b0, 8'd0,   6'd0};
    tbl[9]  = '{10'd157, 10'd407, 24'h123456, 1'b1, 1'b0, 8'd77,  6'd7};
    tbl[10] = '{10'd477, 10'd407, 24'h123456, 1'b1, 1'b1, 8'd77,  6'd7};
    tbl[11] = '{10'd0,   10'd0,   24'h777777, 1'b0, 1'b0, 8'd0,   6'd0};
    tbl[12] = '{10'd639, 10'd479, 24'h888888, 1'b0, 1'b0, 8'd0,   6'd0};

    reset = 1'b1; pixel_x = 10'd0; pixel_y = 10'd0; frame_start = 1'b0;
    bg_data = 24'd0; sel_toggle = 1'b0; confirm = 1'b0;
    step(); step(); step();
    chk("rst_btn_x_pos", 24'(btn_x_pos), 24'd0);
    chk("rst_btn_y_pos", 24'(btn_y_pos), 24'd0);
    chk("rst_btn_type", 24'(btn_type), 24'd0);
    chk("rst_out_data", out_data, 24'd0);
    chk("rst_choice_valid", 24'(choice_valid), 24'd0);
    chk("rst_choice", 24'(choice), 24'd0);
    reset = 1'b0;
    step();

    // Highlight on button 0.
    run_scan(0, 12, 1'b0, 1'b1);

    // Move highlight to button 1.
    sel_toggle = 1'b1; step(); sel_toggle = 1'b0; step();
    run_scan(0, 12, 1'b1, 1'b1);

    // Confirm with simultaneous toggle: highlight stays on button 1.
    cv_snap = cv_count;
    confirm = 1'b1; sel_toggle = 1'b1; step();
    confirm = 1'b0; sel_toggle = 1'b0; step();
    run_scan(6, 6, 1'b1, 1'b0);          // counter 0: blink off
    pulse_frames(2);
    run_scan(6, 6, 1'b1, 1'b1);          // counter 2: blink on
    sel_toggle = 1'b1; step(); sel_toggle = 1'b0;
    confirm = 1'b1; step(); confirm = 1'b0; step();
    pulse_frames(13);
    chk("no_early_choice_valid", 24'(cv_count - cv_snap), 24'd0);
    pulse_frames(1);
    step(); step();
    chk("choice_valid_pulses", 24'(cv_count - cv_snap), 24'd1);
    chk("choice_at_pulse", 24'(cv_choice), 24'd1);
    chk("choice_held", 24'(choice), 24'd1);
    chk("choice_valid_low", 24'(choice_valid), 24'd0);

    // Back in IDLE: toggle works again.
    sel_toggle = 1'b1; step(); sel_toggle = 1'b0; step();
    run_scan(0, 0, 1'b0, 1'b1);

    // Reset part-way through a flash sequence.
    cv_snap = cv_count;
    confirm = 1'b1; step(); confirm = 1'b0; step();
    pulse_frames(5);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midflash_choice", 24'(choice), 24'd0);
    chk("midflash_choice_valid", 24'(choice_valid), 24'd0);
    m_lx = 8'd0; m_ly = 6'd0; m_typ = 1'b0;
    step();
    pulse_frames(20);
    chk("midflash_no_pulse", 24'(cv_count - cv_snap), 24'd0);
    run_scan(0, 1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
